uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//  UART transmitter, the TX counterpart of the oversampled receive path.
//  Accepts a parallel byte on a one-cycle valid strobe. Serialises it as
//  start, data LSB-first, optional parity and one stop bit.
//  Each bit is held Prescale CLK cycles, using the same oversampling clock
//  and Prescale encoding as the receiver, so RX and TX share one baud setup.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame (bit counter is $clog2(DATA_WIDTH) wide)
// PORTS
//  CLK         in   1           oversampling clock, all logic on posedge
//  RST         in   1           async active-low reset
//  P_DATA      in   DATA_WIDTH  payload, sampled only when accepted
//  Data_Valid  in   1           one-cycle request to send P_DATA
//  PAR_EN      in   1           1 = insert parity bit after data
//  PAR_TYP     in   1           0 = even parity, 1 = odd parity
//  Prescale    in   6           CLK cycles per bit: 4, 8, 16 or 32 only
//  TX_OUT      out  1           serial line, idle high
//  Busy        out  1           1 while a frame is in flight
// BEHAVIOUR
//  Reset (RST=0, async, any time incl. mid-frame):
//  - TX_OUT=1, Busy=0, state=IDLE, all counters and latches cleared.
//  - An aborted frame is never resumed.
//  Outputs are registered; no combinational path from inputs to TX_OUT/Busy.
//  Accept condition:
//  - Edge where state=IDLE, Data_Valid=1 and Prescale is legal.
//  - On that edge P_DATA, PAR_EN, PAR_TYP and Prescale are latched.
//  - Later input changes have no effect on the frame.
//  Illegal Prescale (not 4/8/16/32) in IDLE: Data_Valid ignored, TX_OUT stays 1.
//  Data_Valid while Busy=1: ignored, no queueing, latched data unchanged.
//  FSM, transitions on bit boundaries:
//  - IDLE -> START on accept.
//  - START -> DATA.
//  - DATA -> PARITY after bit DATA_WIDTH-1, if PAR_EN.
//  - DATA -> STOP after bit DATA_WIDTH-1, if !PAR_EN.
//  - PARITY -> STOP.
//  - STOP -> IDLE.
//  TX_OUT value per state:
//  - IDLE: 1.  START: 0.  DATA: data[bit_cnt], bit 0 first.
//  - PARITY: ^data if PAR_TYP=0, ~^data if PAR_TYP=1.  STOP: 1.
//  Bit timing:
//  - 5-bit edge_cnt runs 0..Prescale_latched-1 in every non-IDLE state.
//  - Bit boundary = edge with edge_cnt==Prescale-1; edge_cnt wraps to 0 there.
//  - bit_cnt increments on DATA boundaries, cleared on leaving DATA.
//  Accept at edge N:
//  - From edge N, TX_OUT=0 and Busy=1.
//  - Frame length F = (DATA_WIDTH+2+PAR_EN)*Prescale cycles.
//  - At edge N+F: state=IDLE, Busy=0, TX_OUT stays 1.
//  Earliest next accept is edge N+F+1, giving at least 1 extra idle-high cycle.
//  Busy=1 exactly in the non-IDLE states.
// TESTING
//  Reset then P_DATA=8'hA5, PAR_EN=0, Prescale=8, Data_Valid for 1 cycle:
//  - TX_OUT = 0,1,0,1,0,0,1,0,1,1 (LSB-first), each bit held 8 cycles.
//  - Busy high for 80 cycles.
//  P_DATA=8'h03, PAR_EN=1, PAR_TYP=0, Prescale=16:
//  - Parity bit = 0, frame = 176 cycles.
//  - Repeat with PAR_TYP=1: parity bit = 1.
//  Prescale=4 and 32 with 8'hFF, PAR_EN=1, PAR_TYP=1:
//  - Bit widths 4/32 cycles, parity = 1, total 44/352 cycles.
//  Data_Valid with 8'h55 pulsed at cycle 20 of an 8'h0F frame (Prescale=8):
//  - 8'h0F frame is unchanged, no second frame follows.
//  - Prescale=6 in IDLE plus Data_Valid: TX_OUT stays 1, Busy stays 0.
//  Assert RST=0 during DATA bit 3:
//  - Same cycle TX_OUT=1, Busy=0.
//  - After release, a new 8'h3C frame transmits correctly.
//  Back-to-back: Data_Valid held high continuously:
//  - Frames separated by exactly 1 idle-high cycle.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, LSB-first data, optional parity, one stop.
// Each bit lasts Prescale oversampling clocks, matching the receive path.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            edge_cnt_q, edge_cnt_d;
  logic [4:0]            pm1_q, pm1_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic legal;
  logic bound;

  always_comb begin
    legal = (Prescale == 6'd4) || (Prescale == 6'd8) ||
            (Prescale == 6'd16) || (Prescale == 6'd32);
    bound = (edge_cnt_q == pm1_q);

    state_d    = state_q;
    pm1_d      = pm1_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    edge_cnt_d = 5'd0;

    if (state_q != IDLE && !bound) begin
      edge_cnt_d = edge_cnt_q + 5'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (Data_Valid && legal) begin
          state_d   = START;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          pm1_d     = 5'(Prescale - 6'd1);
        end
      end
      START: begin
        if (bound) state_d = DATA;
      end
      DATA: begin
        if (bound) begin
          if (bit_cnt_q == LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bound) state_d = STOP;
      end
      STOP: begin
        if (bound) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change on the edge
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_cnt_d];
      PARITY:  tx_d = par_typ_d ? ~^data_d : ^data_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      pm1_q      <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      pm1_q      <= pm1_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
